// File: rtl/pp_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pp_stage_ctrl
// Description : Sequencing controller for the fetch->decode stage register.
//               The register carries the opcode and operand field. Each
//               cycle it either loads the fetched instruction, holds its
//               contents (multi-cycle stall or halt), or loads a NOP bubble
//               (flush after a taken jump). The controller also drives the
//               PC stall back to fetch.
//
// Ports       : clk            system clock, rising edge
//               reset          asynchronous, active-low reset
//               fetchValid     opcodeIn/fieldIn hold a valid instruction
//               opcodeIn       fetched opcode
//               fieldIn        fetched operand field
//               branchTaken    execute resolved a taken jump/call/return
//               multiCycleReq  instruction in stage needs extra cycles
//               multiCycleDone multi-cycle operation completes this cycle
//               haltReq        level request to freeze the pipeline
//               opcodeOut      registered opcode to decoder
//               fieldOut       registered field to decoder
//               validOut       outputs hold a real instruction
//               pcStall        fetch must hold the PC (combinational)
//               stateOut       0 RUN, 1 STALL, 2 FLUSH, 3 HALT
//               stallTimeout   sticky stall watchdog flag
//
// Options     : PP_STALL_TIMEOUT_EN - when defined, a STALL that reaches
//               STALL_MAX cycles sets stallTimeout and is forced back to RUN.
//               When undefined, stallTimeout is tied low and no watchdog
//               counter exists.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pp_stage_ctrl #(
    parameter int                    OPCODE_LEN   = 5,
    parameter int                    FIELD_LEN    = 10,
    parameter logic [OPCODE_LEN-1:0] NOP_OPCODE   = '0,
    parameter int                    FLUSH_CYCLES = 2,
    parameter int                    STALL_MAX    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetchValid,
    input  logic [OPCODE_LEN-1:0] opcodeIn,
    input  logic [FIELD_LEN-1:0]  fieldIn,
    input  logic                  branchTaken,
    input  logic                  multiCycleReq,
    input  logic                  multiCycleDone,
    input  logic                  haltReq,
    output logic [OPCODE_LEN-1:0] opcodeOut,
    output logic [FIELD_LEN-1:0]  fieldOut,
    output logic                  validOut,
    output logic                  pcStall,
    output logic [1:0]            stateOut,
    output logic                  stallTimeout
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_STALL = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    // Register update selector
    localparam logic [1:0] c_REG_HOLD  = 2'd0;
    localparam logic [1:0] c_REG_FETCH = 2'd1;
    localparam logic [1:0] c_REG_NOP   = 2'd2;

    // Remaining bubbles after the one loaded on the branch edge itself
    localparam logic [2:0] c_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    // With a single bubble the branch edge already inserts it, so no FLUSH
    localparam logic [1:0] c_FLUSH_NEXT   = (FLUSH_CYCLES > 1) ? c_ST_FLUSH : c_ST_RUN;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [2:0]            r_flushCnt;
    logic [OPCODE_LEN-1:0] r_opcode;
    logic [FIELD_LEN-1:0]  r_field;
    logic                  r_valid;

    logic [1:0]            w_nextState;
    logic [1:0]            w_regSel;
    logic [2:0]            w_nextFlushCnt;
    logic                  w_stallClr;
    logic                  w_timeoutHit;

`ifdef PP_STALL_TIMEOUT_EN
    localparam int                c_SCNT_W   = $clog2(STALL_MAX + 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_MAX = c_SCNT_W'(STALL_MAX);

    logic [c_SCNT_W-1:0] r_stallCnt;
    logic [c_SCNT_W-1:0] w_stallCntInc;
    logic                r_stallTimeout;

    // Saturating increment; the value this STALL cycle will leave behind
    assign w_stallCntInc = (r_stallCnt == c_SCNT_MAX) ? r_stallCnt : r_stallCnt + 1'b1;
    assign w_timeoutHit  = (w_stallCntInc == c_SCNT_MAX);
`else
    assign w_timeoutHit  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state decision. branchTaken wins in every state, then haltReq
    // (honoured only from RUN/HALT), then the multi-cycle handshake.
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState    = r_state;
        w_regSel       = c_REG_HOLD;
        w_nextFlushCnt = r_flushCnt;
        w_stallClr     = 1'b0;

        if (branchTaken) begin
            w_nextState    = c_FLUSH_NEXT;
            w_regSel       = c_REG_NOP;
            w_nextFlushCnt = c_FLUSH_RELOAD;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (haltReq) begin
                        w_nextState = c_ST_HALT;
                    end else if (multiCycleReq && !multiCycleDone) begin
                        // Req together with Done is a zero-length stall
                        w_nextState = c_ST_STALL;
                        w_stallClr  = 1'b1;
                    end else begin
                        w_regSel = c_REG_FETCH;
                    end
                end
                c_ST_STALL: begin
                    // Register held; it is released by the next RUN load
                    if (multiCycleDone || w_timeoutHit) begin
                        w_nextState = c_ST_RUN;
                    end
                end
                c_ST_FLUSH: begin
                    w_regSel = c_REG_NOP;
                    if (r_flushCnt <= 3'd1) begin
                        w_nextState    = c_ST_RUN;
                        w_nextFlushCnt = 3'd0;
                    end else begin
                        w_nextFlushCnt = r_flushCnt - 3'd1;
                    end
                end
                c_ST_HALT: begin
                    if (!haltReq) begin
                        w_nextState = c_ST_RUN;
                    end
                end
                default: begin
                    w_nextState = c_ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_RUN;
            r_flushCnt <= 3'd0;
            r_opcode   <= NOP_OPCODE;
            r_field    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_flushCnt <= w_nextFlushCnt;
            case (w_regSel)
                c_REG_FETCH: begin
                    // An empty fetch slot becomes a bubble
                    r_opcode <= fetchValid ? opcodeIn : NOP_OPCODE;
                    r_field  <= fetchValid ? fieldIn  : '0;
                    r_valid  <= fetchValid;
                end
                c_REG_NOP: begin
                    r_opcode <= NOP_OPCODE;
                    r_field  <= '0;
                    r_valid  <= 1'b0;
                end
                default: begin
                    r_opcode <= r_opcode;
                    r_field  <= r_field;
                    r_valid  <= r_valid;
                end
            endcase
        end
    end

`ifdef PP_STALL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt     <= '0;
            r_stallTimeout <= 1'b0;
        end else begin
            if (w_stallClr) begin
                r_stallCnt <= '0;
            end else if (r_state == c_ST_STALL) begin
                r_stallCnt <= w_stallCntInc;
            end
            // Only a timeout that actually ends the stall is flagged
            if ((r_state == c_ST_STALL) && !branchTaken && w_timeoutHit) begin
                r_stallTimeout <= 1'b1;
            end
        end
    end

    assign stallTimeout = r_stallTimeout;
`else
    assign stallTimeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs. pcStall is forced low while reset is held so fetch is not
    // frozen by a next-state decision that reset is overriding.
    // ------------------------------------------------------------------
    assign pcStall = reset &
                     ((w_nextState == c_ST_STALL) || (w_nextState == c_ST_HALT) ||
                      ((r_state == c_ST_STALL) && !multiCycleDone) ||
                      ((r_state == c_ST_HALT) && haltReq));

    assign opcodeOut = r_opcode;
    assign fieldOut  = r_field;
    assign validOut  = r_valid;
    assign stateOut  = r_state;

endmodule
`default_nettype wire
